// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Imported by the top, the starvation counter and available to benches.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 20;
  localparam int DATA_W_DEF     = 32;
  localparam int BE_W           = 4;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DS = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data-stage and memory-side handshakes of the arbiter.
// master = arbiter view, slave = pipeline stages plus memory model view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              ds_req;
  logic              ds_we;
  logic [3:0]        ds_be;
  logic [ADDR_W-1:0] ds_addr;
  logic [DATA_W-1:0] ds_wdata;
  logic [DATA_W-1:0] ds_rdata;
  logic              ds_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_ready,
    input  ds_req, ds_we, ds_be, ds_addr, ds_wdata,
    output ds_rdata, ds_ready,
    output mem_addr, mem_re, mem_we, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_ready,
    output ds_req, ds_we, ds_be, ds_addr, ds_wdata,
    input  ds_rdata, ds_ready,
    input  mem_addr, mem_re, mem_we, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants made while fetch was waiting; saturates at
// STARVE_MAX and then forces the next contested grant to fetch.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant,
  input  logic grant_ds,
  input  logic if_waiting,
  output logic force_if
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (grant) begin
      if (grant_ds && if_waiting) begin
        cnt <= sat_inc(cnt, MAX_CNT);
      end else begin
        cnt <= '0;
      end
    end
  end

  assign force_if = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store stage,
// running one strobe/wait/response transaction at a time with data priority.
//
// state | meaning
// IDLE  | no transaction; sample requests and latch the winner
// ISSUE | one-cycle mem_re or mem_we strobe
// WAIT  | hold address/be/wdata until mem_ready
// RESP  | one-cycle ready pulse to the owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus,
  output logic               busy,
  output logic               owner
);

  arb_state_t        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              re_strobe_q;
  logic              we_strobe_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ds_rdata_q;
  logic              if_ready_q;
  logic              ds_ready_q;

  logic any_req;
  logic pick_ds;
  logic grant;
  logic force_if;

  // Data wins a contested grant unless fetch has been starved long enough.
  always_comb begin
    any_req = bus.if_req | bus.ds_req;
    pick_ds = bus.ds_req & ~(bus.if_req & force_if);
    grant   = (state == IDLE) & any_req;
  end

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .grant      (grant),
    .grant_ds   (pick_ds),
    .if_waiting (bus.if_req),
    .force_if   (force_if)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      re_strobe_q <= 1'b0;
      we_strobe_q <= 1'b0;
      if_rdata_q  <= '0;
      ds_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      ds_ready_q  <= 1'b0;
      busy        <= 1'b0;
      owner       <= OWN_IF;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            busy  <= 1'b1;
            state <= ISSUE;
            if (pick_ds) begin
              owner       <= OWN_DS;
              addr_q      <= bus.ds_addr;
              be_q        <= bus.ds_be;
              wdata_q     <= bus.ds_wdata;
              we_q        <= bus.ds_we;
              re_strobe_q <= ~bus.ds_we;
              we_strobe_q <= bus.ds_we;
            end else begin
              // Fetches are always full-word reads.
              owner       <= OWN_IF;
              addr_q      <= bus.if_addr;
              be_q        <= '1;
              wdata_q     <= '0;
              we_q        <= 1'b0;
              re_strobe_q <= 1'b1;
              we_strobe_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          re_strobe_q <= 1'b0;
          we_strobe_q <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.mem_ready) begin
            if (owner == OWN_DS) begin
              ds_ready_q <= 1'b1;
              if (!we_q) ds_rdata_q <= bus.mem_rdata;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if_ready_q <= 1'b0;
          ds_ready_q <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_re    = re_strobe_q;
  assign bus.mem_we    = we_strobe_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ds_rdata  = ds_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.ds_ready  = ds_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: request agents, a latency-configurable
// memory model, and a negedge monitor that pops expected transactions/responses.
module tb_mem_port_arbiter;

  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic owner;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_txn_t;

  mem_txn_t      exp_mem_q[$];
  mem_txn_t      ds_pend_q[$];
  logic [AW-1:0] if_pend_q[$];
  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_ds_q[$];
  logic [DW-1:0] if_model = '0;
  logic [DW-1:0] ds_model = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_strobe = 0;
  int n_if_ready = 0;
  int n_ds_ready = 0;
  int lat_q[$];
  int ds_t_q[$];
  int mem_lat = 1;
  bit mem_stuck = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 20'h00010) return 32'hE3A00001;
    return {a[11:0], a} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [10:0] outs_nz();
    return {|bus.if_rdata, |bus.ds_rdata, bus.if_ready, bus.ds_ready, |bus.mem_addr,
            bus.mem_re, bus.mem_we, |bus.mem_be, |bus.mem_wdata, busy, owner};
  endfunction

  task automatic req_if(input logic [AW-1:0] a);
    if_pend_q.push_back(a);
    if_model = mem_data(a);
    exp_if_q.push_back(if_model);
  endtask

  task automatic req_ds(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    mem_txn_t t;
    t.we = we; t.be = be; t.addr = a; t.wdata = wd;
    ds_pend_q.push_back(t);
    if (!we) ds_model = mem_data(a);
    exp_ds_q.push_back(ds_model);
  endtask

  task automatic exp_mem(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    mem_txn_t t;
    t.we = we; t.be = be; t.addr = a; t.wdata = wd;
    exp_mem_q.push_back(t);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_mem_q.size() != 0 || exp_if_q.size() != 0 || exp_ds_q.size() != 0 ||
            if_pend_q.size() != 0 || ds_pend_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < budget, 1'b1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin : if_agent
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.if_req && bus.if_ready) begin
        @(posedge clk); #1;
        bus.if_req = 1'b0;
      end else if (!bus.if_req && if_pend_q.size() > 0) begin
        bus.if_addr = if_pend_q.pop_front();
        bus.if_req  = 1'b1;
      end
    end
  end

  initial begin : ds_agent
    mem_txn_t t;
    bus.ds_req = 1'b0; bus.ds_we = 1'b0; bus.ds_be = '0;
    bus.ds_addr = '0;  bus.ds_wdata = '0;
    forever begin
      @(negedge clk);
      if (bus.ds_req && bus.ds_ready) begin
        @(posedge clk); #1;
        bus.ds_req = 1'b0;
      end else if (!bus.ds_req && ds_pend_q.size() > 0) begin
        t = ds_pend_q.pop_front();
        bus.ds_we = t.we; bus.ds_be = t.be; bus.ds_addr = t.addr; bus.ds_wdata = t.wdata;
        bus.ds_req = 1'b1;
      end
    end
  end

  initial begin : mem_model
    logic [DW-1:0] d;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = mem_stuck;
      if (bus.mem_re || bus.mem_we) begin
        d = mem_data(bus.mem_addr);
        if (mem_stuck) begin
          bus.mem_rdata = d;
        end else begin
          repeat (mem_lat) @(negedge clk);
          bus.mem_ready = 1'b1;
          bus.mem_rdata = d;
          @(negedge clk);
          bus.mem_ready = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    mem_txn_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_re || bus.mem_we) begin
          last_strobe = cyc;
          check("mem_strobe_expected", exp_mem_q.size() != 0, 1'b1);
          if (exp_mem_q.size() != 0) begin
            e = exp_mem_q.pop_front();
            check("mem_addr", bus.mem_addr, e.addr);
            check("mem_re", bus.mem_re, !e.we);
            check("mem_we", bus.mem_we, e.we);
            if (e.we) begin
              check("mem_be", bus.mem_be, e.be);
              check("mem_wdata", bus.mem_wdata, e.wdata);
            end
          end
        end
        check("ready_onehot", bus.if_ready & bus.ds_ready, 1'b0);
        if (bus.if_ready) begin
          n_if_ready++;
          lat_q.push_back(cyc - last_strobe);
          check("if_ready_owner", owner, 1'b0);
          check("if_ready_busy", busy, 1'b1);
          check("if_ready_expected", exp_if_q.size() != 0, 1'b1);
          if (exp_if_q.size() != 0) check("if_rdata", bus.if_rdata, exp_if_q.pop_front());
        end
        if (bus.ds_ready) begin
          n_ds_ready++;
          lat_q.push_back(cyc - last_strobe);
          ds_t_q.push_back(cyc);
          check("ds_ready_owner", owner, 1'b1);
          check("ds_ready_busy", busy, 1'b1);
          check("ds_ready_expected", exp_ds_q.size() != 0, 1'b1);
          if (exp_ds_q.size() != 0) check("ds_rdata", bus.ds_rdata, exp_ds_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int saved;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_nz(), 11'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs_nz(), 11'd0);
    #1;

    // Fetch only, memory answers two cycles after the strobe
    mem_lat = 2;
    lat_q.delete();
    exp_mem(1'b0, 4'hF, 20'h00010, '0);
    req_if(20'h00010);
    wait_done("t1_done", 50);
    check("t1_if_rdata", bus.if_rdata, 32'hE3A00001);
    check("t1_lat_count", lat_q.size(), 1);
    check("t1_latency", lat_q.size() > 0 ? lat_q[0] : -1, 3);
    check("t1_ds_ready_count", n_ds_ready, 0);
    check("t1_owner", owner, 1'b0);

    // Simultaneous requests: data first, then fetch
    mem_lat = 1;
    exp_mem(1'b0, 4'hF, 20'h00200, '0);
    exp_mem(1'b0, 4'hF, 20'h00040, '0);
    req_ds(1'b0, 4'hF, 20'h00200, '0);
    req_if(20'h00040);
    wait_done("t2_done", 50);
    check("t2_owner_last", owner, 1'b0);
    check("t2_ds_rdata", bus.ds_rdata, mem_data(20'h00200));

    // Store leaves ds_rdata and if_rdata untouched
    exp_mem(1'b1, 4'b0011, 20'h00300, 32'h12345678);
    req_ds(1'b1, 4'b0011, 20'h00300, 32'h12345678);
    wait_done("t3_done", 50);
    check("t3_ds_rdata_kept", bus.ds_rdata, mem_data(20'h00200));
    check("t3_if_rdata_kept", bus.if_rdata, mem_data(20'h00040));
    check("t3_owner_last", owner, 1'b1);

    // Starvation: D,D,D,D,I,D,D,D,D,I,D,D
    for (int i = 0; i < 10; i++) begin
      if (i == 4) exp_mem(1'b0, 4'hF, 20'h00080, '0);
      if (i == 8) exp_mem(1'b0, 4'hF, 20'h00084, '0);
      exp_mem(1'b0, 4'hF, 20'h00400 + AW'(i * 4), '0);
    end
    for (int i = 0; i < 10; i++) req_ds(1'b0, 4'hF, 20'h00400 + AW'(i * 4), '0);
    req_if(20'h00080);
    req_if(20'h00084);
    wait_done("t4_done", 200);
    check("t4_ds_rdata", bus.ds_rdata, mem_data(20'h00424));
    check("t4_if_rdata", bus.if_rdata, mem_data(20'h00084));

    // mem_ready stuck high (also high during ISSUE): 4 cycles per transaction
    mem_stuck = 1'b1;
    @(negedge clk); #1;
    lat_q.delete();
    ds_t_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_mem(1'b0, 4'hF, 20'h00500 + AW'(i * 4), '0);
      req_ds(1'b0, 4'hF, 20'h00500 + AW'(i * 4), '0);
    end
    exp_mem(1'b1, 4'b1100, 20'h0050C, 32'hA5A5_0F0F);
    req_ds(1'b1, 4'b1100, 20'h0050C, 32'hA5A5_0F0F);
    wait_done("t5_done", 100);
    check("t5_ready_count", ds_t_q.size(), 4);
    for (int i = 1; i < ds_t_q.size(); i++) check("t5_spacing", ds_t_q[i] - ds_t_q[i-1], 4);
    for (int i = 0; i < lat_q.size(); i++) check("t5_latency", lat_q[i], 2);
    check("t5_ds_rdata_kept", bus.ds_rdata, mem_data(20'h00508));
    mem_stuck = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Reset asserted in WAIT abandons the transaction
    mem_lat = 6;
    exp_mem(1'b0, 4'hF, 20'h000A0, '0);
    req_if(20'h000A0);
    n = 0;
    while (!bus.mem_re && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_strobe_seen", n < 50, 1'b1);
    @(negedge clk);
    check("t6_busy_in_wait", busy, 1'b1);
    saved = n_if_ready;
    rst_n = 1'b0;
    bus.if_req = 1'b0;
    #1;
    check("t6_reset_outputs", outs_nz(), 11'd0);
    exp_if_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_ready", n_if_ready, saved);
    check("t6_idle_after", busy, 1'b0);
    #1;
    mem_lat = 1;
    exp_mem(1'b0, 4'hF, 20'h000B0, '0);
    req_if(20'h000B0);
    wait_done("t6_done", 50);
    check("t6_if_rdata", bus.if_rdata, mem_data(20'h000B0));
    check("t6_if_ready_count", n_if_ready, saved + 1);

    check("final_queues_empty", exp_mem_q.size() + exp_if_q.size() + exp_ds_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
